// File: rtl/stall_pkg.sv
// rtl/stall_pkg.sv - shared types and constants for the semiMIPS stall controller
package stall_pkg;

    // Mul/div tracker states
    typedef enum logic {
        RUN    = 1'b0,
        MDBUSY = 1'b1
    } md_state_t;

    // Register 0 is hardwired to zero, so it never carries a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default mul/div latency in cycles
    localparam int MDLAT_DEFAULT = 32;

    // Width of the mul/div down-counter
    localparam int CNT_W = 8;

    // True when a producer register feeds either decode source operand
    function automatic logic feeds_decode(
        input logic [4:0] producer,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return (producer != REG_ZERO) && ((producer == rs) || (producer == rt));
    endfunction

endpackage

// File: rtl/muldiv_busy_counter.sv
// rtl/muldiv_busy_counter.sv - mul/div busy tracker: RUN/MDBUSY FSM with latency down-counter
module muldiv_busy_counter
    import stall_pkg::*;
#(
    parameter int MDLAT = MDLAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic MulDivStartE,
    output logic Busy
);

    // Loaded on issue; the busy window ends on the edge that sees zero,
    // which gives exactly MDLAT busy cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDLAT - 1);

    md_state_t        state;
    md_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // State and counter registers, cleared asynchronously so a reset mid-operation aborts the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter update; a start while busy is ignored since decode already stalls it
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            RUN: begin
                if (MulDivStartE) begin
                    state_next = MDBUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            MDBUSY: begin
                if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Busy is a pure decode of the state
    always_comb begin
        Busy = (state == MDBUSY);
    end

endmodule

// File: rtl/stallcontroller.sv
// rtl/stallcontroller.sv - semiMIPS hazard detection, fetch/decode enables, execute flush and stall counter
module stallcontroller
    import stall_pkg::*;
#(
    parameter int MDLAT = MDLAT_DEFAULT,
    parameter int SCW   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     RsD,
    input  logic [4:0]     RtD,
    input  logic           BranchD,
    input  logic           HiLoUseD,
    input  logic [4:0]     RtE,
    input  logic [4:0]     WriteRegE,
    input  logic           MemtoRegE,
    input  logic           RegWriteE,
    input  logic [4:0]     WriteRegM,
    input  logic           MemtoRegM,
    input  logic           MulDivStartE,
    output logic           PCEn,
    output logic           FDEn,
    output logic           FlushE,
    output logic           Busy,
    output logic [SCW-1:0] StallCount
);

    localparam logic [SCW-1:0] SC_ONE = SCW'(1);
    localparam logic [SCW-1:0] SC_MAX = '1;

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall;
    logic md_busy;

    muldiv_busy_counter #(
        .MDLAT(MDLAT)
    ) u_muldiv_busy_counter (
        .clk         (clk),
        .reset       (reset),
        .MulDivStartE(MulDivStartE),
        .Busy        (md_busy)
    );

    // Hazard terms: load-use, branch operand still in flight (E or M), and HI/LO read while mul/div runs
    always_comb begin
        lwstall     = MemtoRegE && feeds_decode(RtE, RsD, RtD);
        branchstall = BranchD &&
                      ((RegWriteE && feeds_decode(WriteRegE, RsD, RtD)) ||
                       (MemtoRegM && feeds_decode(WriteRegM, RsD, RtD)));
        mdstall     = md_busy && HiLoUseD;
        stall       = lwstall || branchstall || mdstall;
    end

    // Pipeline controls; reset forces a frozen front end with a flushed execute stage
    always_comb begin
        if (reset) begin
            PCEn   = 1'b0;
            FDEn   = 1'b0;
            FlushE = 1'b1;
            Busy   = 1'b0;
        end else begin
            PCEn   = ~stall;
            FDEn   = ~stall;
            FlushE = stall;
            Busy   = md_busy;
        end
    end

    // Saturating stall-cycle counter: one count per stalled edge regardless of how many causes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
        end else if (stall && (StallCount != SC_MAX)) begin
            StallCount <= StallCount + SC_ONE;
        end
    end

endmodule
